// File: rtl/traffic_phase_sched_pkg.sv
// traffic_pkg: shared types for the four-approach phase scheduler.
// Contents: state encoding, lane count, 2-bit lane type, one-hot lane helper.
package traffic_pkg;
   localparam int NUM_LANES = 4;
   typedef logic [1:0] lane_t;
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ALLRED = 2'd1,
      S_GREEN  = 2'd2,
      S_YELLOW = 2'd3
   } state_t;
   function automatic logic [NUM_LANES-1:0] onehot(input lane_t l);
      onehot = NUM_LANES'(1) << l;
   endfunction
endpackage

// File: rtl/traffic_phase_sched_rr_lane_picker.sv
// rr_lane_picker: combinational round-robin next-lane selection.
// Ports: last - lane that owned the previous phase
//        req  - per-lane request vector
//        next - first requesting lane scanning last+1, +2, +3, +0; last+1 when req is empty
module rr_lane_picker
   import traffic_pkg::*;
(
   input  lane_t                last,
   input  logic [NUM_LANES-1:0] req,
   output lane_t                next
);
   // Scan from the farthest offset down so the closest requesting lane wins.
   always_comb begin
      next = last + 2'd1;
      for (int k = NUM_LANES; k >= 1; k--)
         if (req[lane_t'(last + lane_t'(k))]) next = last + lane_t'(k);
   end
endmodule

// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: round-robin four-approach phase scheduler with min/max green.
// Ports: clk, reset (sync, active-low), enable (low = orderly shutdown to all-red),
//        car_req[3:0] vehicle presence, ev_req[3:0] emergency preempt (only with
//        TRAFFIC_EV_PREEMPT_EN), green/yellow one-hot registered lamps, red = ~(green|yellow),
//        active_lane = lane owning the current or last phase.
// Macro: TRAFFIC_EV_PREEMPT_EN adds the ev_req port and emergency preemption.
module traffic_phase_sched
   import traffic_pkg::*;
#(
   parameter int GREEN_MIN = 3,
   parameter int GREEN_MAX = 6,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int CW        = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_LANES-1:0] car_req,
`ifdef TRAFFIC_EV_PREEMPT_EN
   input  logic [NUM_LANES-1:0] ev_req,
`endif
   output logic [NUM_LANES-1:0] green,
   output logic [NUM_LANES-1:0] yellow,
   output logic [NUM_LANES-1:0] red,
   output lane_t                active_lane
);
   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_LANES-1:0] green_q, green_d, yellow_q, yellow_d;
   lane_t                lane_q, lane_d, pick, pick_last;
   logic [NUM_LANES-1:0] pick_req;
   logic                 ev_any, ev_own, other, go_yellow;
`ifdef TRAFFIC_EV_PREEMPT_EN
   // Emergency override reuses the picker: scanning from lane 3 yields the lowest set bit.
   assign ev_any    = |ev_req;
   assign ev_own    = ev_req[lane_q];
   assign pick_last = ev_any ? 2'd3 : lane_q;
   assign pick_req  = ev_any ? ev_req : car_req;
`else
   assign ev_any    = 1'b0;
   assign ev_own    = 1'b0;
   assign pick_last = lane_q;
   assign pick_req  = car_req;
`endif
   rr_lane_picker u_picker (
      .last (pick_last),
      .req  (pick_req),
      .next (pick)
   );
   assign other     = |(car_req & ~onehot(lane_q));
   assign go_yellow = !enable || (ev_any && !ev_own) ||
                      (!ev_own && other && ((cnt_q >= CW'(GREEN_MIN-1) && !car_req[lane_q]) ||
                                            cnt_q == CW'(GREEN_MAX-1)));
   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      case (state_q)
         S_IDLE:   if (enable) state_d = S_ALLRED;
         S_ALLRED: if (cnt_q == CW'(ALLRED_T-1)) begin
            state_d = enable ? S_GREEN : S_IDLE;
            lane_d  = enable ? pick : lane_q;
         end
         S_GREEN:  if (go_yellow) state_d = S_YELLOW;
         S_YELLOW: if (cnt_q == CW'(YELLOW_T-1)) state_d = S_ALLRED;
         default:  state_d = S_IDLE;
      endcase
      // Counter restarts on every state change and parks at GREEN_MAX-1.
      cnt_d    = (state_d != state_q) ? '0 : (cnt_q == CW'(GREEN_MAX-1)) ? cnt_q : cnt_q + 1'b1;
      green_d  = (state_d == S_GREEN)  ? onehot(lane_d) : '0;
      yellow_d = (state_d == S_YELLOW) ? onehot(lane_d) : '0;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         green_q  <= '0;
         yellow_q <= '0;
         lane_q   <= 2'd3;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         green_q  <= green_d;
         yellow_q <= yellow_d;
         lane_q   <= lane_d;
      end
   end
   assign green       = green_q;
   assign yellow      = yellow_q;
   assign red         = ~(green_q | yellow_q);
   assign active_lane = lane_q;
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: scoreboard bench for traffic_phase_sched (default parameters).
module tb_traffic_phase_sched;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] car_req = 4'b0;
`ifdef TRAFFIC_EV_PREEMPT_EN
   logic [3:0] ev_req = 4'b0;
`endif
   logic [3:0] green, yellow, red;
   logic [1:0] active_lane;
   int         checks = 0;
   int         failures = 0;

   typedef struct packed {
      logic [3:0] g;
      logic [3:0] y;
      logic [1:0] l;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   traffic_phase_sched dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .car_req     (car_req),
`ifdef TRAFFIC_EV_PREEMPT_EN
      .ev_req      (ev_req),
`endif
      .green       (green),
      .yellow      (yellow),
      .red         (red),
      .active_lane (active_lane)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] g, input logic [3:0] y, input logic [1:0] l, input int n);
      exp_t x;
      x.g = g;
      x.y = y;
      x.l = l;
      for (int k = 0; k < n; k++) sb.push_back(x);
   endtask

   task automatic do_reset(input logic [3:0] cr);
      reset   = 1'b0;
      enable  = 1'b1;
      car_req = cr;
`ifdef TRAFFIC_EV_PREEMPT_EN
      ev_req  = 4'b0;
`endif
      repeat (2) tick();
      reset = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      enable  = 1'b1;
      car_req = 4'b1111;
      repeat (2) tick();
      checks++;
      if (red !== 4'b1111) begin failures++; $display("FAIL reset_red got=%b exp=1111", red); end
      checks++;
      if (green !== 4'b0000) begin failures++; $display("FAIL reset_green got=%b exp=0000", green); end
      checks++;
      if (yellow !== 4'b0000) begin failures++; $display("FAIL reset_yellow got=%b exp=0000", yellow); end
      checks++;
      if (active_lane !== 2'd3) begin failures++; $display("FAIL reset_lane got=%0d exp=3", active_lane); end
   endtask

   task automatic test_single();
      int n;
      do_reset(4'b0001);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0001, 4'b0000, 2'd0, 22);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({green, yellow, red, active_lane} !== {e.g, e.y, ~(e.g | e.y), e.l}) begin
            failures++;
            $display("FAIL single[%0d] got g=%b y=%b r=%b lane=%0d exp g=%b y=%b lane=%0d",
                     i, green, yellow, red, active_lane, e.g, e.y, e.l);
         end
      end
   endtask

   task automatic test_max_green();
      int n;
      do_reset(4'b0101);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0001, 4'b0000, 2'd0, 6);
      push(4'b0000, 4'b0001, 2'd0, 2);
      push(4'b0000, 4'b0000, 2'd0, 1);
      push(4'b0100, 4'b0000, 2'd2, 6);
      push(4'b0000, 4'b0100, 2'd2, 2);
      push(4'b0000, 4'b0000, 2'd2, 1);
      push(4'b0001, 4'b0000, 2'd0, 1);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({green, yellow, red, active_lane} !== {e.g, e.y, ~(e.g | e.y), e.l}) begin
            failures++;
            $display("FAIL max_green[%0d] got g=%b y=%b r=%b lane=%0d exp g=%b y=%b lane=%0d",
                     i, green, yellow, red, active_lane, e.g, e.y, e.l);
         end
      end
   endtask

   task automatic test_min_green();
      int n;
      do_reset(4'b0001);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0001, 4'b0000, 2'd0, 3);
      push(4'b0000, 4'b0001, 2'd0, 2);
      push(4'b0000, 4'b0000, 2'd0, 1);
      push(4'b0100, 4'b0000, 2'd2, 3);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({green, yellow, red, active_lane} !== {e.g, e.y, ~(e.g | e.y), e.l}) begin
            failures++;
            $display("FAIL min_green[%0d] got g=%b y=%b r=%b lane=%0d exp g=%b y=%b lane=%0d",
                     i, green, yellow, red, active_lane, e.g, e.y, e.l);
         end
         if (i == 1) car_req = 4'b0100;
      end
   endtask

   task automatic test_shutdown();
      int n;
      do_reset(4'b0001);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0001, 4'b0000, 2'd0, 2);
      push(4'b0000, 4'b0001, 2'd0, 2);
      push(4'b0000, 4'b0000, 2'd0, 5);
      push(4'b0010, 4'b0000, 2'd1, 3);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({green, yellow, red, active_lane} !== {e.g, e.y, ~(e.g | e.y), e.l}) begin
            failures++;
            $display("FAIL shutdown[%0d] got g=%b y=%b r=%b lane=%0d exp g=%b y=%b lane=%0d",
                     i, green, yellow, red, active_lane, e.g, e.y, e.l);
         end
         if (i == 2) enable = 1'b0;
         if (i == 8) begin
            enable  = 1'b1;
            car_req = 4'b0000;
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset(4'b1010);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0010, 4'b0000, 2'd1, 6);
      push(4'b0000, 4'b0010, 2'd1, 2);
      push(4'b0000, 4'b0000, 2'd1, 1);
      push(4'b1000, 4'b0000, 2'd3, 6);
      push(4'b0000, 4'b1000, 2'd3, 2);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0010, 4'b0000, 2'd1, 2);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({green, yellow, red, active_lane} !== {e.g, e.y, ~(e.g | e.y), e.l}) begin
            failures++;
            $display("FAIL back_to_back[%0d] got g=%b y=%b r=%b lane=%0d exp g=%b y=%b lane=%0d",
                     i, green, yellow, red, active_lane, e.g, e.y, e.l);
         end
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({green, yellow, red, active_lane} !== {4'b0000, 4'b0000, 4'b1111, 2'd3}) begin
         failures++;
         $display("FAIL midphase_reset got g=%b y=%b r=%b lane=%0d exp g=0000 y=0000 r=1111 lane=3",
                  green, yellow, red, active_lane);
      end
   endtask

`ifdef TRAFFIC_EV_PREEMPT_EN
   task automatic test_preempt();
      int n;
      do_reset(4'b0001);
      push(4'b0000, 4'b0000, 2'd3, 1);
      push(4'b0001, 4'b0000, 2'd0, 1);
      push(4'b0000, 4'b0001, 2'd0, 2);
      push(4'b0000, 4'b0000, 2'd0, 1);
      push(4'b1000, 4'b0000, 2'd3, 10);
      n = sb.size();
      for (int i = 0; i < n; i++) begin
         tick();
         e = sb.pop_front();
         checks++;
         if ({green, yellow, red, active_lane} !== {e.g, e.y, ~(e.g | e.y), e.l}) begin
            failures++;
            $display("FAIL preempt[%0d] got g=%b y=%b r=%b lane=%0d exp g=%b y=%b lane=%0d",
                     i, green, yellow, red, active_lane, e.g, e.y, e.l);
         end
         if (i == 1) ev_req = 4'b1000;
      end
      ev_req = 4'b0000;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_max_green();
      test_min_green();
      test_shutdown();
      test_back_to_back();
`ifdef TRAFFIC_EV_PREEMPT_EN
      test_preempt();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/traffic_phase_sched.md
# traffic_phase_sched

Four-approach phase scheduler for the smart traffic light controller. It decides which approach receives right-of-way and sequences that approach through green, yellow and all-red clearance. Arbitration between approaches is round-robin, driven by the vehicle-presence sensors, with minimum and maximum green times enforced. It sits above the per-lane lamp/timer logic and drives its one-hot lamp outputs directly.

## Interface
- `GREEN_MIN`, 3: minimum green cycles once contended; 1 ≤ GREEN_MIN ≤ GREEN_MAX
- `GREEN_MAX`, 6: maximum green cycles while another lane requests; < 2^CW
- `YELLOW_T`, 2: yellow cycles; ≥ 1
- `ALLRED_T`, 1: all-red clearance cycles; ≥ 1
- `CW`, 8: phase counter width
- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-low reset
- `enable` in 1: run request; low means orderly shutdown to all-red
- `car_req` in 4: per-lane vehicle presence, bit i = lane i, level-sensitive
- `ev_req` in 4: emergency preempt per lane; present only with the macro
- `green` out 4: one-hot green lamp, registered
- `yellow` out 4: one-hot yellow lamp, registered
- `red` out 4: red lamps, `~(green|yellow)`
- `active_lane` out 2: lane owning the current or last phase

## Operation
- States: IDLE, ALLRED, GREEN, YELLOW. Entering any state clears `cnt`; `cnt` increments each cycle and saturates at GREEN_MAX-1.
- Reset (`reset`=0 at an edge): state IDLE, cnt=0, green=0, yellow=0, red=4'b1111, active_lane=2'd3. The reset value of 3 makes the first scan start at lane 0. Reset overrides everything, mid-phase included.
- IDLE: all red. `enable`=1 → ALLRED.
- ALLRED: all red; lasts ALLRED_T cycles. On the last cycle:
  - `enable`=0 → IDLE.
  - Otherwise → GREEN for the next lane and active_lane updates.
  - Next lane = first lane with `car_req` set, scanning active_lane+1, +2, +3, +0 (mod 4).
  - If no request is set, next lane = active_lane+1 (mod 4).
- GREEN: green=onehot(active_lane). "other" means `|(car_req & ~onehot(active_lane))`. Go to YELLOW when any of these holds:
  - `enable`=0 (immediate; ignores GREEN_MIN).
  - other && cnt ≥ GREEN_MIN-1 && !car_req[active_lane].
  - other && cnt == GREEN_MAX-1.
- GREEN with no other request: hold indefinitely.
- YELLOW: yellow=onehot(active_lane); lasts YELLOW_T cycles, then → ALLRED.
- At most one bit of green|yellow is set at any time. No green is ever adjacent to another lane's green without YELLOW then ALLRED in between.

## Timing
- All outputs change only on rising `clk` edges.
- Exit decisions use inputs sampled on the last cycle of the state; the new state and lamps are visible the next cycle.
- State duration N means lamps show that state for exactly N cycles.
- Contended green, own lane still requesting: exactly GREEN_MAX cycles.
- Contended green, own lane idle: exactly max(GREEN_MIN, cycles until contention appears) cycles.
- `enable` falling in GREEN: yellow on the next cycle, then YELLOW_T + ALLRED_T cycles, then IDLE.
- `enable` falling in YELLOW or ALLRED: the current sequence completes, then IDLE.
- `enable` returning in IDLE: ALLRED next cycle. The scan resumes from the preserved active_lane.

## Configuration
- `TRAFFIC_EV_PREEMPT_EN` defined: the `ev_req` port exists.
  - In GREEN, if `ev_req` is nonzero and `ev_req[active_lane]`=0: → YELLOW next cycle, ignoring GREEN_MIN.
  - At ALLRED exit, if `ev_req` is nonzero, next lane = lowest-index set bit of `ev_req`, overriding round-robin.
  - If `ev_req[active_lane]`=1 in GREEN: stay green, ignoring GREEN_MAX.
- Undefined: no `ev_req` port and no preemption logic; behaviour is exactly the base description.

## Structure
- Package `traffic_pkg` holds:
  - State encoding: S_IDLE=0, S_ALLRED=1, S_GREEN=2, S_YELLOW=3.
  - `NUM_LANES`=4 and the 2-bit lane type.
- Sub-module `rr_lane_picker`: combinational; inputs last lane and request vector; outputs next lane per the scan rule above. It is shared with the emergency-override mux.

## Test plan
Default parameters throughout.
- Reset: hold `reset`=0 for 2 cycles with `enable`=1 → red=1111, green=0, yellow=0, active_lane=3. The state is IDLE in the first post-reset cycle.
- Single requester: `enable`=1, `car_req`=0001 → 1 all-red cycle, then green=0001 held for 20+ cycles.
- Max green: lane 0 green, `car_req`=0101 held → green=0001 for exactly 6 cycles, yellow=0001 for 2, all-red for 1, then green=0100 with active_lane=2.
- Min green: lane 0 green, `car_req`=0100 from green cycle 0 → green for exactly 3 cycles, then yellow.
- Shutdown mid-green: drop `enable` at green cycle 1 → yellow the next cycle, 2 yellow, 1 all-red, then IDLE with red=1111. Re-enable → the next grant scans from active_lane+1.
- Preempt (macro on): lane 0 green, `ev_req`=1000 at green cycle 0 → yellow next cycle, then after clearance green=1000 regardless of `car_req`.
